// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB packet transmit path.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC,
    EOP
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h8005;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;

  // Bit-reverse a 16-bit word; turns the MSB-first polynomial into its LSB-first form.
  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 in reflected (LSB-first) form; one data bit per enabled cycle.
module usb_crc16_serial
  import usb_tx_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc,
  output logic [15:0] crc_next
);

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  // crc_next lets the sequencer capture the value that includes the bit being sent now.
  always_comb begin
    crc_next = {1'b0, crc[15:1]} ^ ((crc[0] ^ din) ? POLY_REFL : 16'h0000);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      crc <= 16'h0000;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// Packet TX sequencer: serialises SYNC, PID, payload and CRC16 LSB-first, then requests EOP.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       start,
  input  logic [7:0] pid,
  input  logic       has_data,
  input  logic       crc_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       stuff_stall,
  output logic       bit_out,
  output logic       bit_en,
  output logic       eop_req,
  input  logic       eop_done,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] shift;
  logic [2:0]  bit_cnt;
  logic        crc_hi;
  logic [7:0]  pid_r;
  logic        has_data_r;
  logic        crc_en_r;
  logic        last_r;
  logic        done_r;

  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [15:0] crc_src;

  logic sending;
  logic advance;
  logic field_end;
  logic fetch;
  logic take;
  logic crc_load;
  logic accept;

  always_comb begin
    sending   = (state == SYNC) || (state == PID) || (state == DATA) || (state == CRC);
    advance   = sending && !stuff_stall;
    field_end = advance && (bit_cnt == 3'd7) && ((state != CRC) || crc_hi);
    fetch     = field_end && (((state == PID) && has_data_r) || ((state == DATA) && !last_r));
    take      = fetch && tx_valid;
    crc_load  = field_end && crc_en_r &&
                (((state == PID) && !has_data_r) || ((state == DATA) && last_r));
    accept    = (state == IDLE) && start;
    // In DATA the final bit is being folded in this very cycle, so use the look-ahead value.
    crc_src   = (state == DATA) ? crc_next : crc;
  end

  usb_crc16_serial #(
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk      (clk),
    .nRST     (nRST),
    .clr      (accept),
    .en       ((state == DATA) && advance),
    .din      (shift[0]),
    .crc      (crc),
    .crc_next (crc_next)
  );

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == EOP) && eop_done;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SYNC;
      SYNC: if (field_end) state_nxt = PID;
      PID: begin
        if (field_end) begin
          if (has_data_r)    state_nxt = tx_valid ? DATA : EOP;
          else if (crc_en_r) state_nxt = CRC;
          else               state_nxt = EOP;
        end
      end
      DATA: begin
        if (field_end) begin
          if (last_r) state_nxt = crc_en_r ? CRC : EOP;
          else        state_nxt = tx_valid ? DATA : EOP;
        end
      end
      CRC:  if (field_end) state_nxt = EOP;
      EOP:  if (eop_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bit_en   = sending;
    bit_out  = sending && shift[0];
    tx_ready = fetch;
    underrun = fetch && !tx_valid;
    eop_req  = (state == EOP);
    busy     = (state != IDLE);
    done     = done_r;
  end

  // Shift register, bit counter and latched packet fields
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      shift      <= 16'h0000;
      bit_cnt    <= 3'd0;
      crc_hi     <= 1'b0;
      pid_r      <= 8'h00;
      has_data_r <= 1'b0;
      crc_en_r   <= 1'b0;
      last_r     <= 1'b0;
    end else if (accept) begin
      pid_r      <= pid;
      has_data_r <= has_data;
      crc_en_r   <= crc_en;
      shift      <= {8'h00, SYNC_BYTE};
      bit_cnt    <= 3'd0;
      crc_hi     <= 1'b0;
      last_r     <= 1'b0;
    end else if (advance) begin
      bit_cnt <= bit_cnt + 3'd1;
      if ((state == CRC) && (bit_cnt == 3'd7)) crc_hi <= 1'b1;
      if (field_end && (state == SYNC)) begin
        shift <= {8'h00, pid_r};
      end else if (take) begin
        shift  <= {8'h00, tx_data};
        last_r <= tx_last;
      end else if (crc_load) begin
        shift <= ~crc_src;
      end else begin
        shift <= {1'b0, shift[15:1]};
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Packet-level bench: expected wire bits queued per packet, popped on every advancing bit.
`timescale 1ns/1ps
module tb_usb_tx_sequencer;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pid = 8'h00;
  logic       has_data = 1'b0;
  logic       crc_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       stuff_stall = 1'b0;
  logic       eop_done = 1'b0;
  logic       tx_ready, bit_out, bit_en, eop_req, busy, done, underrun;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk         (clk),
    .nRST        (nRST),
    .start       (start),
    .pid         (pid),
    .has_data    (has_data),
    .crc_en      (crc_en),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .stuff_stall (stuff_stall),
    .bit_out     (bit_out),
    .bit_en      (bit_en),
    .eop_req     (eop_req),
    .eop_done    (eop_done),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  typedef struct {
    logic [7:0]  pid;
    bit          has_data;
    bit          crc_en;
    int          nbytes;
    int          kind;       // 0 none, 1 ASCII "123456789", 2 random
    bit          crc_known;
    logic [15:0] exp_crc;
    int          sa, la, sb, lb;
    bit          valid_low;
    bit          noise;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] pay [16];
  bit         exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (r[0] ^ pay[i][b]) r = (r >> 1) ^ 16'hA001;
        else                  r = r >> 1;
      end
    end
    return ~r;
  endfunction

  task automatic fill_payload(input int kind, input int n);
    for (int i = 0; i < 16; i++) begin
      if (kind == 1)      pay[i] = 8'h31 + 8'(i);
      else if (kind == 2) pay[i] = 8'($urandom_range(0, 255));
      else                pay[i] = 8'h00;
    end
    if (n > 16) $display("payload too long");
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    int popped = 0, used_a = 0, used_b = 0, ptr = 0;
    int readies = 0, unders = 0, en_cycles = 0, eop_seen = 0, cyc = 0, nbits;
    int exp_ready;
    bit fin = 0;
    logic [15:0] c;
    exp_q.delete();
    push_byte(8'h80);
    push_byte(v.pid);
    if (!v.valid_low) begin
      if (v.has_data) for (int i = 0; i < v.nbytes; i++) push_byte(pay[i]);
      if (v.crc_en) begin
        c = v.crc_known ? v.exp_crc : model_crc(v.has_data ? v.nbytes : 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(c[i]);
      end
    end
    nbits = exp_q.size();
    exp_ready = v.valid_low ? 1 : (v.has_data ? v.nbytes : 0);

    @(posedge clk); #1;
    start = 1'b1; pid = v.pid; has_data = v.has_data; crc_en = v.crc_en;
    while (!fin && cyc < 3000) begin
      tx_valid = v.has_data && !v.valid_low && (ptr < v.nbytes);
      tx_data  = (ptr < 16) ? pay[ptr] : 8'h00;
      tx_last  = (ptr == v.nbytes - 1);
      stuff_stall = 1'b0;
      if (popped == v.sa && used_a < v.la) begin
        stuff_stall = 1'b1; used_a++;
      end else if (popped == v.sb && used_b < v.lb) begin
        stuff_stall = 1'b1; used_b++;
      end
      if (v.noise && eop_seen >= 1) stuff_stall = 1'b1;
      if (v.noise && cyc == 6) start = 1'b1;
      eop_done = (eop_seen >= 2) || (v.noise && cyc == 6);
      @(negedge clk);
      if (bit_en) begin
        en_cycles++;
        if (!stuff_stall) begin
          if (exp_q.size() == 0) check({tag, " extra_bit"}, 1, 0);
          else check({tag, " bit"}, bit_out, exp_q.pop_front());
          popped++;
        end
      end
      if (tx_ready) begin
        readies++;
        if (tx_valid) ptr++;
      end
      if (underrun) unders++;
      if (eop_req) eop_seen++;
      if (done) begin
        fin = 1;
        check({tag, " eop_req_after_done"}, eop_req, 0);
      end
      @(posedge clk); #1;
      start = 1'b0; eop_done = 1'b0; stuff_stall = 1'b0; cyc++;
    end
    tx_valid = 1'b0;
    if (!fin) check({tag, " timeout_done"}, 0, 1);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " idle_after"}, busy, 0);
    check({tag, " bits_left"}, exp_q.size(), 0);
    check({tag, " bit_en_cycles"}, en_cycles, nbits + v.la + v.lb);
    check({tag, " tx_ready_count"}, readies, exp_ready);
    check({tag, " underrun_count"}, unders, v.valid_low ? 1 : 0);
    check({tag, " eop_req_cycles"}, eop_seen, 3);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " bit_en"}, bit_en, 0);
    check({tag, " bit_out"}, bit_out, 0);
    check({tag, " tx_ready"}, tx_ready, 0);
    check({tag, " eop_req"}, eop_req, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " underrun"}, underrun, 0);
  endtask

  initial begin
    //           pid        hd crc n  kind known crc       sa  la sb  lb vlow noise
    vecs[0] = '{PID_ACK,   0, 0, 0, 0, 1'b0, 16'h0000, -1, 0, -1, 0, 0, 1};
    vecs[1] = '{PID_DATA0, 0, 1, 0, 0, 1'b1, 16'h0000, -1, 0, -1, 0, 0, 0};
    vecs[2] = '{PID_DATA1, 1, 1, 9, 1, 1'b1, 16'hB4C8, -1, 0, -1, 0, 0, 0};
    vecs[3] = '{PID_DATA0, 1, 1, 9, 1, 1'b1, 16'hB4C8, 11, 1, 23, 2, 0, 0};
    vecs[4] = '{PID_DATA1, 1, 1, 4, 2, 1'b0, 16'h0000, -1, 0, -1, 0, 1, 0};
    vecs[5] = '{PID_DATA0, 1, 1, 5, 2, 1'b0, 16'h0000, -1, 0, -1, 0, 0, 0};
    vecs[6] = '{PID_DATA1, 1, 0, 3, 2, 1'b0, 16'h0000, -1, 0, -1, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk) nRST = 1'b1;

    for (int k = 0; k < 7; k++) begin
      fill_payload(vecs[k].kind, vecs[k].nbytes);
      run_pkt(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset in the middle of the payload, then a clean packet.
    fill_payload(1, 9);
    @(posedge clk); #1;
    start = 1'b1; pid = PID_DATA1; has_data = 1'b1; crc_en = 1'b1;
    tx_valid = 1'b1; tx_data = pay[0]; tx_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) @(posedge clk);
    #1 check("mid_busy", busy, 1);
    check("mid_bit_en", bit_en, 1);
    nRST = 1'b0;
    #1 check_quiet("async_reset");
    @(negedge clk) check_quiet("held_reset");
    tx_valid = 1'b0;
    nRST = 1'b1;
    run_pkt(vecs[2], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
